// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : IDLE/RUN/HALT fetch unit with a loadable 16-bit instruction memory
//            that feeds a decoder one registered word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [15:0]       redirect_pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  output logic [15:0]       pc,
  output logic [15:0]       instruction,
  output logic [15:0]       instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] C_OP_HALT = 4'hF;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [15:0] r_ipc, w_ipc_nxt;
  logic        r_valid, w_valid_nxt;
  logic [15:0] r_mem [DEPTH];
  logic [15:0] w_rdata;

  // Index is the low pc bits, so addresses past DEPTH alias back into memory.
  assign w_rdata = r_mem[r_pc[ADDR_W-1:0]];

  // Memory has no reset so a loaded program survives a reset.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 16'h0000;
      r_ipc   <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A redirect discards this cycle's fetch even when stalled.
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_valid_nxt = 1'b0;
        end else if (!stall) begin
          w_instr_nxt = w_rdata;
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          if (w_rdata[15:12] == C_OP_HALT) begin
            w_state_nxt = S_HALT;
          end else begin
            w_pc_nxt = r_pc + 16'd1;
          end
        end
      end
      S_HALT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign pc          = r_pc;
  assign instruction = r_instr;
  assign instr_pc    = r_ipc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire
